iseq_slot_feeder: RTL

//  Buffers a host instruction program, then streams it as even/odd instruction pairs into instr_dispatcher's
//  two slot inputs (en_in0/instr_in0, en_in1/instr_in1). Upstream of instr_dispatcher, downstream of host FIFO.

---
 rtl/iseq_slot_feeder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/iseq_slot_feeder.sv
// Buffers a host program in even/odd banks, then streams it as instruction pairs into the two dispatcher slots.
// First pair reaches the slots 3 cycles after END; a pair refills the slots only once both are free.
module iseq_slot_feeder #(
  parameter int ADDR_WIDTH = 10,
  parameter int PF_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  input  logic [31:0] host_instr,
  output logic        host_ready,
  output logic        en_out0,
  output logic [31:0] instr_out0,
  input  logic        en_ack0,
  output logic        en_out1,
  output logic [31:0] instr_out1,
  input  logic        en_ack1,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int PW = $clog2(PF_DEPTH);
  localparam int BD = 2 ** (ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] FULL_IDX = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
  localparam logic [PW:0]         PF_LIM   = (PW + 1)'(PF_DEPTH);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic        v1;
    logic [31:0] i1;
    logic [31:0] i0;
  } pair_t;

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   end_idx;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [31:0]           bank0 [BD];
  logic [31:0]           bank1 [BD];
  pair_t                 rd_dat;
  logic                  rd_vld;
  pair_t                 pf_mem [PF_DEPTH];
  logic [PW-1:0]         pf_wp;
  logic [PW-1:0]         pf_rp;
  logic [PW:0]           pf_count;

  logic        host_fire, is_end, at_last;
  logic        rd_more, rd_issue;
  logic [PW:0] pf_fill;
  logic        consume0, consume1, slots_free;
  logic        pf_empty, head_avail, slot_load, pf_push, pf_pop, exec_done;
  pair_t       head;

  assign host_fire  = host_valid & host_ready;
  assign is_end     = (host_instr[31:28] == 4'h0);
  assign at_last    = (wr_ptr == LAST_IDX);

  // Credit counts the read still in the RAM pipe so the prefetch queue can never overrun.
  assign rd_more    = ({rd_ptr, 1'b0} < end_idx);
  assign pf_fill    = pf_count + (PW + 1)'(rd_vld);
  assign rd_issue   = (state == S_EXEC) && rd_more && (pf_fill < PF_LIM);

  assign consume0   = en_out0 & en_ack0;
  assign consume1   = en_out1 & en_ack1;
  assign slots_free = (~en_out0 | consume0) & (~en_out1 | consume1);

  // An empty queue is bypassed so a fresh RAM read can land straight in the slots.
  assign pf_empty   = (pf_count == '0);
  assign head_avail = ~pf_empty | rd_vld;
  assign head       = pf_empty ? rd_dat : pf_mem[pf_rp];
  assign slot_load  = (state == S_EXEC) && slots_free && head_avail;
  assign pf_pop     = slot_load & ~pf_empty;
  assign pf_push    = rd_vld & ~(slot_load & pf_empty);
  assign exec_done  = (state == S_EXEC) && !rd_more && !rd_vld && pf_empty && slots_free;

  assign busy = (state == S_EXEC) || (state == S_DONE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (host_fire) begin
      if (wr_ptr[0]) bank1[wr_ptr[ADDR_WIDTH-1:1]] <= host_instr;
      else           bank0[wr_ptr[ADDR_WIDTH-1:1]] <= host_instr;
    end
    if (rd_issue) begin
      rd_dat.i0 <= bank0[rd_ptr[ADDR_WIDTH-2:0]];
      rd_dat.i1 <= bank1[rd_ptr[ADDR_WIDTH-2:0]];
      rd_dat.v1 <= ({rd_ptr, 1'b1} < end_idx);
    end
    if (pf_push) pf_mem[pf_wp] <= rd_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      wr_ptr     <= '0;
      end_idx    <= '0;
      rd_ptr     <= '0;
      rd_vld     <= 1'b0;
      pf_wp      <= '0;
      pf_rp      <= '0;
      pf_count   <= '0;
      en_out0    <= 1'b0;
      en_out1    <= 1'b0;
      instr_out0 <= '0;
      instr_out1 <= '0;
      host_ready <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rd_vld <= rd_issue;
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (pf_push)  pf_wp  <= pf_wp + PW'(1);
      if (pf_pop)   pf_rp  <= pf_rp + PW'(1);
      pf_count <= pf_count + (PW + 1)'(pf_push) - (PW + 1)'(pf_pop);

      if (slot_load) begin
        en_out0    <= 1'b1;
        instr_out0 <= head.i0;
        en_out1    <= head.v1;
        instr_out1 <= head.i1;
      end else begin
        if (consume0) en_out0 <= 1'b0;
        if (consume1) en_out1 <= 1'b0;
      end

      case (state)
        S_LOAD: begin
          host_ready <= 1'b1;
          if (host_fire) begin
            wr_ptr   <= wr_ptr + (ADDR_WIDTH + 1)'(1);
            overflow <= at_last & ~is_end;
            if (is_end || at_last) begin
              end_idx    <= is_end ? wr_ptr : FULL_IDX;
              state      <= S_EXEC;
              host_ready <= 1'b0;
            end
          end
        end
        S_EXEC: begin
          if (exec_done) state <= S_DONE;
        end
        S_DONE: begin
          state      <= S_LOAD;
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          host_ready <= 1'b1;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
